// File: rtl/serv_mem_bridge_if.sv
// Wishbone-style bus between the serial memory bridge and its memory.
// The master modport is the bridge side.
interface serv_mem_bridge_if;
  logic [29:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (
    output adr, dat, sel, we, cyc,
    input  rdt, ack
  );

  modport slave (
    input  adr, dat, sel, we, cyc,
    output rdt, ack
  );
endinterface

// File: rtl/serv_mem_bridge.sv
// Bit-serial load/store bridge: assembles store words from a serial stream,
// runs one bus cycle, then replays aligned/extended load data one bit per step.
module serv_mem_bridge #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_rs2,
  input  logic                     i_start,
  input  logic                     i_we,
  input  logic [1:0]               i_size,
  input  logic                     i_signed,
  input  logic [31:0]              i_adr,
  serv_mem_bridge_if.master        wb,
  output logic                     o_rd,
  output logic                     o_ready,
  output logic                     o_misalign,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RDOUT
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] dat;
  logic [4:0]  cnt;
  logic        we_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [1:0]  lsb_r;
  logic [29:0] adr_r;

  logic        misaligned;
  logic        accept;
  logic        reject;
  logic        ack_done;

  logic [3:0]  sel;
  logic [31:0] wdat;
  logic        in_range;
  logic        sign_bit;

  assign misaligned = ((i_size == 2'b01) && i_adr[0]) ||
                      ((i_size == 2'b10) && (i_adr[1:0] != 2'b00));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    ack_done   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (ALIGN_CHECK && misaligned) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = BUS;
          end
        end
      end
      BUS: begin
        if (wb.ack) begin
          ack_done   = 1'b1;
          state_next = we_r ? IDLE : RDOUT;
        end
      end
      RDOUT: begin
        if (i_en && (cnt == 5'd31)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // dat doubles as the store shift register in IDLE and the load result in RDOUT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dat        <= 32'd0;
      cnt        <= 5'd0;
      we_r       <= 1'b0;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      lsb_r      <= 2'b00;
      adr_r      <= 30'd0;
      o_ready    <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      o_ready    <= ack_done;
      o_misalign <= reject;
      if (accept) begin
        we_r     <= i_we;
        size_r   <= i_size;
        signed_r <= i_signed;
        lsb_r    <= i_adr[1:0];
        adr_r    <= i_adr[31:2];
      end
      case (state)
        IDLE: begin
          if (i_en) dat <= {i_rs2, dat[31:1]};
        end
        BUS: begin
          if (ack_done && !we_r) begin
            dat <= wb.rdt >> {lsb_r, 3'b000};
            cnt <= 5'd0;
          end
        end
        RDOUT: begin
          if (i_en) cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sel  = 4'b1111;
    wdat = dat;
    case (size_r)
      2'b00: begin
        sel  = 4'b0001 << lsb_r;
        wdat = {4{dat[7:0]}};
      end
      2'b01: begin
        sel  = lsb_r[1] ? 4'b1100 : 4'b0011;
        wdat = {2{dat[15:0]}};
      end
      default: begin
        sel  = 4'b1111;
        wdat = dat;
      end
    endcase
  end

  // Bits beyond the access width come from the sign bit or zero
  always_comb begin
    in_range = 1'b1;
    sign_bit = dat[7];
    case (size_r)
      2'b00:   in_range = (cnt[4:3] == 2'b00);
      2'b01: begin
        in_range = ~cnt[4];
        sign_bit = dat[15];
      end
      default: in_range = 1'b1;
    endcase
  end

  assign o_rd   = (state == RDOUT) & (in_range ? dat[cnt] : (signed_r & sign_bit));
  assign o_busy = (state != IDLE);

  assign wb.adr = adr_r;
  assign wb.dat = wdat;
  assign wb.sel = sel;
  assign wb.we  = we_r & (state == BUS);
  assign wb.cyc = (state == BUS);

endmodule

// File: tb/tb_serv_mem_bridge.sv
// Directed bench for serv_mem_bridge; runs an ALIGN_CHECK=1 and an ALIGN_CHECK=0
// instance side by side on identical stimulus.
module tb_serv_mem_bridge;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_en = 1'b0;
  logic        i_rs2 = 1'b0;
  logic        i_start = 1'b0;
  logic        i_we = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic        i_signed = 1'b0;
  logic [31:0] i_adr = 32'd0;
  logic [31:0] rdt = 32'd0;
  logic        ack = 1'b0;

  logic rd_a, ready_a, misalign_a, busy_a;
  logic rd_b, ready_b, misalign_b, busy_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] result;

  always #5 i_clk = ~i_clk;

  serv_mem_bridge_if wb_a ();
  serv_mem_bridge_if wb_b ();

  assign wb_a.rdt = rdt;
  assign wb_a.ack = ack;
  assign wb_b.rdt = rdt;
  assign wb_b.ack = ack;

  serv_mem_bridge #(.ALIGN_CHECK(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_rs2(i_rs2),
    .i_start(i_start), .i_we(i_we), .i_size(i_size), .i_signed(i_signed),
    .i_adr(i_adr), .wb(wb_a), .o_rd(rd_a), .o_ready(ready_a),
    .o_misalign(misalign_a), .o_busy(busy_a)
  );

  serv_mem_bridge #(.ALIGN_CHECK(1'b0)) dut_noalign (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_rs2(i_rs2),
    .i_start(i_start), .i_we(i_we), .i_size(i_size), .i_signed(i_signed),
    .i_adr(i_adr), .wb(wb_b), .o_rd(rd_b), .o_ready(ready_b),
    .o_misalign(misalign_b), .o_busy(busy_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] adr);
    i_we     = we;
    i_size   = size;
    i_signed = sgn;
    i_adr    = adr;
    i_start  = 1'b1;
    tick();
    i_start  = 1'b0;
  endtask

  task automatic shiftWord(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      i_rs2 = w[i];
      i_en  = 1'b1;
      tick();
    end
    i_en  = 1'b0;
    i_rs2 = 1'b0;
  endtask

  task automatic ackCycle(input logic [31:0] data);
    rdt = data;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Collects 32 serial result bits; optionally raises i_start at one step
  task automatic readSerial(output logic [31:0] r, input int start_at);
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) checkOutput("busy_before_last", {31'd0, busy_a}, 32'd1);
      if (i == start_at + 1) checkOutput("cyc_after_rdout_start", {31'd0, wb_a.cyc}, 32'd0);
      r[i]    = rd_a;
      i_en    = 1'b1;
      i_start = (i == start_at);
      tick();
      i_start = 1'b0;
    end
    i_en = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    checkOutput("reset_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("reset_cyc", {31'd0, wb_a.cyc}, 32'd0);
    checkOutput("reset_ready", {31'd0, ready_a}, 32'd0);
    checkOutput("reset_misalign", {31'd0, misalign_a}, 32'd0);
    checkOutput("reset_rd", {31'd0, rd_a}, 32'd0);

    // Word store with wait states
    shiftWord(32'hDEADBEEF);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0100);
    checkOutput("ws_cyc", {31'd0, wb_a.cyc}, 32'd1);
    checkOutput("ws_adr", {2'd0, wb_a.adr}, 32'h40);
    checkOutput("ws_sel", {28'd0, wb_a.sel}, 32'hF);
    checkOutput("ws_we", {31'd0, wb_a.we}, 32'd1);
    checkOutput("ws_dat", wb_a.dat, 32'hDEADBEEF);
    i_en  = 1'b1;
    i_rs2 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    i_en  = 1'b0;
    i_rs2 = 1'b0;
    checkOutput("ws_dat_held", wb_a.dat, 32'hDEADBEEF);
    checkOutput("ws_cyc_held", {31'd0, wb_a.cyc}, 32'd1);
    checkOutput("ws_ready_wait", {31'd0, ready_a}, 32'd0);
    ackCycle(32'd0);
    checkOutput("ws_ready", {31'd0, ready_a}, 32'd1);
    checkOutput("ws_cyc_drop", {31'd0, wb_a.cyc}, 32'd0);
    checkOutput("ws_busy_done", {31'd0, busy_a}, 32'd0);
    tick();
    checkOutput("ws_ready_pulse", {31'd0, ready_a}, 32'd0);

    // Signed byte load from the top lane
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0203);
    checkOutput("sb_sel", {28'd0, wb_a.sel}, 32'h8);
    checkOutput("sb_adr", {2'd0, wb_a.adr}, 32'h80);
    checkOutput("sb_we", {31'd0, wb_a.we}, 32'd0);
    checkOutput("sb_rd_in_bus", {31'd0, rd_a}, 32'd0);
    ackCycle(32'h8000_0000);
    checkOutput("sb_ready", {31'd0, ready_a}, 32'd1);
    checkOutput("sb_busy_rdout", {31'd0, busy_a}, 32'd1);
    readSerial(result, -1);
    checkOutput("sb_result", result, 32'hFFFF_FF80);
    checkOutput("sb_busy_end", {31'd0, busy_a}, 32'd0);

    // Unsigned half load from the upper half
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0002);
    checkOutput("uh_sel", {28'd0, wb_a.sel}, 32'hC);
    ackCycle(32'hABCD_1234);
    readSerial(result, -1);
    checkOutput("uh_result", result, 32'h0000_ABCD);

    // Byte store replicates the low byte across lanes
    shiftWord(32'h0000_00A5);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0005);
    checkOutput("bs_sel", {28'd0, wb_a.sel}, 32'h2);
    checkOutput("bs_dat", wb_a.dat, 32'hA5A5_A5A5);
    ackCycle(32'd0);
    checkOutput("bs_ready", {31'd0, ready_a}, 32'd1);

    // Misaligned half: aborted with checking, bus cycle without
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0001);
    checkOutput("mh_misalign", {31'd0, misalign_a}, 32'd1);
    checkOutput("mh_cyc", {31'd0, wb_a.cyc}, 32'd0);
    checkOutput("mh_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("mh_nochk_cyc", {31'd0, wb_b.cyc}, 32'd1);
    checkOutput("mh_nochk_sel", {28'd0, wb_b.sel}, 32'h3);
    checkOutput("mh_nochk_misalign", {31'd0, misalign_b}, 32'd0);
    tick();
    checkOutput("mh_misalign_pulse", {31'd0, misalign_a}, 32'd0);
    ackCycle(32'd0);
    checkOutput("mh_ack_ignored", {31'd0, ready_a}, 32'd0);
    checkOutput("mh_nochk_ready", {31'd0, ready_b}, 32'd1);

    // Misaligned word
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0102);
    checkOutput("mw_misalign", {31'd0, misalign_a}, 32'd1);
    checkOutput("mw_cyc", {31'd0, wb_a.cyc}, 32'd0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;

    // Reset in the middle of a bus cycle
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0300);
    checkOutput("rb_cyc", {31'd0, wb_a.cyc}, 32'd1);
    i_rst = 1'b1;
    ack   = 1'b1;
    tick();
    i_rst = 1'b0;
    ack   = 1'b0;
    checkOutput("rb_cyc_after", {31'd0, wb_a.cyc}, 32'd0);
    checkOutput("rb_busy_after", {31'd0, busy_a}, 32'd0);
    checkOutput("rb_ready_after", {31'd0, ready_a}, 32'd0);
    ackCycle(32'd0);
    checkOutput("rb_late_ack", {31'd0, ready_a}, 32'd0);

    // Start during readout is ignored
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0010);
    ackCycle(32'h1234_5678);
    i_we   = 1'b1;
    i_adr  = 32'h0000_0400;
    readSerial(result, 5);
    checkOutput("sr_result", result, 32'h1234_5678);
    checkOutput("sr_busy_end", {31'd0, busy_a}, 32'd0);
    checkOutput("sr_cyc_end", {31'd0, wb_a.cyc}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
